imm_ext_pipe: RTL and testbench
===============================

Name: imm_ext_pipe

Overview:
- Parametrised, pipelined immediate-extension unit that widens an IN_W-bit immediate to OUT_W bits.
- Four modes: sign-extend, zero-extend, scaled (sign-extend then shift left), and upper-placement.
- Sits between the decode and operand-select stages.
- Upstream and downstream are decoupled by a valid/ready handshake and a 2-entry output buffer, so a downstream stall never drops an immediate.

Parameters:
- IN_W, 18, immediate input width; legal range 2..OUT_W.
- OUT_W, 32, extended output width.
- SHIFT, 2, left-shift amount for scaled mode; legal range 0..OUT_W-1.
- TAG_W, 4, width of a sideband tag carried unchanged alongside each immediate.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream offers an immediate.
- in_ready  out  1  block can accept this cycle.
- in_imm  in  IN_W  raw immediate.
- in_mode  in  2  extension mode: 00 sign, 01 zero, 10 scaled, 11 upper.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  downstream accepts the head entry.
- out_imm  out  OUT_W  extended immediate.
- out_ovf  out  1  significance was lost in scaled mode.
- out_tag  out  TAG_W  tag of the head entry.

Behaviour:
- Reset (rst_n low, asynchronous):
  - buffer count = 0, read/write pointers = 0, all storage = 0.
  - out_valid = 0, out_imm = 0, out_ovf = 0, out_tag = 0.
  - in_ready = 1 one combinational delay after reset release.
- Handshakes:
  - Accept occurs when in_valid && in_ready.
  - Pop occurs when out_valid && out_ready.
  - in_ready = (count != 2), a function of registered count only; in_ready never depends on out_ready combinationally.
  - out_valid = (count != 0).
  - out_imm, out_ovf and out_tag are driven from the head entry registers; there is no combinational path from in_* to out_*.
- Latency:
  - An immediate accepted at edge N appears at the outputs after edge N (out_valid = 1 in cycle N+1) if the buffer was empty.
  - If the buffer was not empty, the immediate appears after all older entries, in strict order.
- Extension, computed combinationally at accept and stored as OUT_W + 1 + TAG_W bits:
  - 00 sign: out = {(OUT_W-IN_W) copies of imm[IN_W-1], imm}; ovf = 0.
  - 01 zero: out = {(OUT_W-IN_W) zeros, imm}; ovf = 0.
  - 10 scaled: s = sign-extend(imm) to OUT_W+SHIFT bits; out = (s << SHIFT) truncated to OUT_W bits.
    - ovf = 1 iff the discarded top SHIFT bits of the shifted value are not all equal to out[OUT_W-1].
    - With the default parameters ovf is always 0.
  - 11 upper: out = imm << (OUT_W-IN_W), low bits zero; ovf = 0.
  - When IN_W == OUT_W, modes 00, 01 and 11 all pass imm unchanged.
- Buffer: 2-entry circular FIFO; pointers wrap 1 -> 0.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Full (count = 2): in_ready = 0; in_valid is ignored and no push occurs; a pop in that cycle frees one slot, and in_ready rises the next cycle.
  - Empty: out_ready is ignored; no pop occurs and there is no underflow.
  - Upstream must hold in_imm, in_mode and in_tag stable while in_valid && !in_ready.
- Mid-operation reset: all buffered entries are discarded immediately and no partially accepted entry survives. The outputs go to their reset values asynchronously.
- Storage is not cleared on pop: out_imm, out_ovf and out_tag may show stale data while out_valid = 0, and the bench must ignore them then.

Test Plan:
- Defaults, out_ready=1; push 18'h20084 mode 00 tag 3 -> one cycle later out_valid=1, out_imm=32'hFFFE0084, out_ovf=0, out_tag=3; then the same imm in mode 01 -> 32'h00020084.
- Defaults; mode 10 with imm 18'h3FFFF, then mode 11 with imm 18'h00001 -> out_imm=32'hFFFFFFFC ovf=0, then 32'h00004000, in order.
- out_ready=0; offer 3 back-to-back immediates A, B, C -> A and B accepted, in_ready=0 with C held; raise out_ready -> A, B, C emerge in order with no loss or duplication.
- Buffer at count 1, continuous in_valid and out_ready for 10 cycles with incrementing tags -> throughput 1 per cycle, count stays 1, tags in order.
- IN_W=16, OUT_W=16, SHIFT=2, mode 10: imm 16'h2000 -> out_imm=16'h8000, ovf=1; imm 16'hF000 -> out_imm=16'hC000, ovf=0.
- Buffer full, assert rst_n=0 mid-cycle -> out_valid=0 immediately (asynchronous); after release in_ready=1 and no stale entry is ever presented.

Source files
------------

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate-extension unit: widens an IN_W-bit immediate to OUT_W bits
// (sign / zero / scaled / upper) and buffers results in a 2-entry FIFO.
module imm_ext_pipe #(
  parameter int IN_W  = 18,
  parameter int OUT_W = 32,
  parameter int SHIFT = 2,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_imm,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag
);

  localparam int ENT_W = OUT_W + 1 + TAG_W;
  localparam int EXT_W = OUT_W + SHIFT;

  // Returns {ovf, extended immediate}.
  function automatic logic [OUT_W:0] extend(input logic [IN_W-1:0] imm,
                                            input logic [1:0] mode);
    logic signed [IN_W-1:0]  imm_s;
    logic signed [EXT_W-1:0] wide_s;
    logic signed [EXT_W-1:0] shifted_s;
    logic signed [OUT_W-1:0] trunc_s;
    logic signed [EXT_W-1:0] back_s;
    logic [OUT_W-1:0]        zext;
    logic [OUT_W-1:0]        res;
    logic                    ovf;
    imm_s     = imm;
    wide_s    = EXT_W'(imm_s);
    shifted_s = wide_s <<< SHIFT;
    trunc_s   = shifted_s[OUT_W-1:0];
    back_s    = EXT_W'(trunc_s);
    zext      = OUT_W'(imm);
    ovf       = 1'b0;
    case (mode)
      2'b00: res = wide_s[OUT_W-1:0];
      2'b01: res = zext;
      2'b10: begin
        res = shifted_s[OUT_W-1:0];
        // Significance lost iff re-extending the truncated result differs from the full shift.
        ovf = (shifted_s != back_s);
      end
      default: res = zext << (OUT_W - IN_W);
    endcase
    return {ovf, res};
  endfunction

  logic [OUT_W-1:0] ext_imm_p0;
  logic             ext_ovf_p0;
  logic             push_p0;
  logic             pop_p0;

  logic [ENT_W-1:0] buf_p1 [2];
  logic [1:0]       cnt_p1;
  logic             wr_ptr_p1;
  logic             rd_ptr_p1;

  assign {ext_ovf_p0, ext_imm_p0} = extend(in_imm, in_mode);

  assign in_ready  = (cnt_p1 != 2'd2);
  assign out_valid = (cnt_p1 != 2'd0);
  assign push_p0   = in_valid && in_ready;
  assign pop_p0    = out_valid && out_ready;

  // Stage p0 -> p1: extended entry written into the circular buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p1    <= 2'd0;
      wr_ptr_p1 <= 1'b0;
      rd_ptr_p1 <= 1'b0;
      buf_p1[0] <= '0;
      buf_p1[1] <= '0;
    end else begin
      if (push_p0) begin
        buf_p1[wr_ptr_p1] <= {ext_ovf_p0, ext_imm_p0, in_tag};
        wr_ptr_p1         <= ~wr_ptr_p1;
      end
      if (pop_p0) begin
        rd_ptr_p1 <= ~rd_ptr_p1;
      end
      case ({push_p0, pop_p0})
        2'b10:   cnt_p1 <= cnt_p1 + 2'd1;
        2'b01:   cnt_p1 <= cnt_p1 - 2'd1;
        default: cnt_p1 <= cnt_p1;
      endcase
    end
  end

  assign {out_ovf, out_imm, out_tag} = buf_p1[rd_ptr_p1];

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed bench for imm_ext_pipe: default 18->32 instance plus a 16->16 instance
// for scaled-mode overflow.
`timescale 1ns/1ps
module tb_imm_ext_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_ovf;
  logic [17:0] in_imm;
  logic [1:0]  in_mode;
  logic [3:0]  in_tag, out_tag;
  logic [31:0] out_imm;

  logic        d2_in_valid, d2_in_ready, d2_out_valid, d2_out_ready, d2_out_ovf;
  logic [15:0] d2_in_imm, d2_out_imm;
  logic [1:0]  d2_in_mode;
  logic [3:0]  d2_in_tag, d2_out_tag;

  imm_ext_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_ovf(out_ovf), .out_tag(out_tag)
  );

  imm_ext_pipe #(.IN_W(16), .OUT_W(16), .SHIFT(2), .TAG_W(4)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(d2_in_valid), .in_ready(d2_in_ready), .in_imm(d2_in_imm), .in_mode(d2_in_mode),
    .in_tag(d2_in_tag), .out_valid(d2_out_valid), .out_ready(d2_out_ready), .out_imm(d2_out_imm),
    .out_ovf(d2_out_ovf), .out_tag(d2_out_tag)
  );

  typedef struct {
    logic [17:0] imm;
    logic [1:0]  mode;
    logic [3:0]  tag;
    logic [31:0] exp_imm;
    logic        exp_ovf;
  } vec_t;

  typedef struct {
    logic [31:0] imm;
    logic        ovf;
    logic [3:0]  tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every pop of the default instance is checked against the order of acceptance.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got imm %0h tag %0h expected no entry", out_imm, out_tag);
      end else begin
        mon_e = sb.pop_front();
        check("pop_imm", 64'(out_imm), 64'(mon_e.imm));
        check("pop_ovf", 64'(out_ovf), 64'(mon_e.ovf));
        check("pop_tag", 64'(out_tag), 64'(mon_e.tag));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [17:0] imm, input logic [1:0] mode, input logic [3:0] tag,
                      input logic [31:0] ei, input logic eo, output int waits, output logic ov);
    exp_t e;
    bit   done;
    done     = 1'b0;
    waits    = 0;
    ov       = 1'b0;
    in_valid = 1'b1;
    in_imm   = imm;
    in_mode  = mode;
    in_tag   = tag;
    while (!done && waits < 20) begin
      @(negedge clk);
      if (in_ready) begin
        e.imm = ei; e.ovf = eo; e.tag = tag;
        sb.push_back(e);
        ov   = out_valid;
        done = 1'b1;
      end else begin
        waits++;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: tag %0h not accepted after %0d cycles, required acceptance", tag, waits);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  vec_t vecs[9];
  vec_t v16[6];
  int   w;
  logic ov;

  initial begin
    vecs[0] = '{18'h20084, 2'b00, 4'h3, 32'hFFFE0084, 1'b0};
    vecs[1] = '{18'h20084, 2'b01, 4'h4, 32'h00020084, 1'b0};
    vecs[2] = '{18'h3FFFF, 2'b10, 4'h5, 32'hFFFFFFFC, 1'b0};
    vecs[3] = '{18'h00001, 2'b11, 4'h6, 32'h00004000, 1'b0};
    vecs[4] = '{18'h1FFFF, 2'b00, 4'h7, 32'h0001FFFF, 1'b0};
    vecs[5] = '{18'h3FFFF, 2'b01, 4'h8, 32'h0003FFFF, 1'b0};
    vecs[6] = '{18'h1FFFF, 2'b10, 4'h9, 32'h0007FFFC, 1'b0};
    vecs[7] = '{18'h3FFFF, 2'b11, 4'hA, 32'hFFFFC000, 1'b0};
    vecs[8] = '{18'h20000, 2'b10, 4'hB, 32'hFFF80000, 1'b0};

    v16[0] = '{18'h02000, 2'b10, 4'h1, 32'h00008000, 1'b1};
    v16[1] = '{18'h0F000, 2'b10, 4'h2, 32'h0000C000, 1'b0};
    v16[2] = '{18'h04000, 2'b10, 4'h3, 32'h00000000, 1'b1};
    v16[3] = '{18'h0F000, 2'b11, 4'h4, 32'h0000F000, 1'b0};
    v16[4] = '{18'h0F000, 2'b00, 4'h5, 32'h0000F000, 1'b0};
    v16[5] = '{18'h08001, 2'b01, 4'h6, 32'h00008001, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_imm = '0; in_mode = '0; in_tag = '0; out_ready = 1'b0;
    d2_in_valid = 1'b0; d2_in_imm = '0; d2_in_mode = '0; d2_in_tag = '0; d2_out_ready = 1'b1;

    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_imm", 64'(out_imm), 64'd0);
    check("rst_out_ovf", 64'(out_ovf), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", 64'(in_ready), 64'd1);
    check("rel_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;

    // Single pushes: one-cycle latency and every extension mode.
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      send(vecs[i].imm, vecs[i].mode, vecs[i].tag, vecs[i].exp_imm, vecs[i].exp_ovf, w, ov);
      in_valid = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("vec%0d_imm", i), 64'(out_imm), 64'(vecs[i].exp_imm));
      check($sformatf("vec%0d_ovf", i), 64'(out_ovf), 64'(vecs[i].exp_ovf));
      check($sformatf("vec%0d_tag", i), 64'(out_tag), 64'(vecs[i].tag));
      @(posedge clk); #1;
    end

    // Backpressure: A and B fill the buffer, C is held until a slot frees.
    out_ready = 1'b0;
    send(18'h00123, 2'b01, 4'h1, 32'h00000123, 1'b0, w, ov);
    send(18'h20000, 2'b00, 4'h2, 32'hFFFE0000, 1'b0, w, ov);
    in_valid = 1'b1; in_imm = 18'h3FFFF; in_mode = 2'b11; in_tag = 4'h3;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("bp_in_ready_full", 64'(in_ready), 64'd0);
      check("bp_head_imm", 64'(out_imm), 64'h00000123);
      check("bp_head_tag", 64'(out_tag), 64'h1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(18'h3FFFF, 2'b11, 4'h3, 32'hFFFFC000, 1'b0, w, ov);
    check("bp_c_wait", 64'(w), 64'd1);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("bp_drained", 64'(sb.size()), 64'd0);

    // Steady streaming at count 1: one accept per cycle.
    out_ready = 1'b0;
    send(18'h00005, 2'b01, 4'h0, 32'h00000005, 1'b0, w, ov);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(18'(i + 16), 2'b01, 4'(i + 1), 32'(i + 16), 1'b0, w, ov);
      check($sformatf("tp%0d_wait", i), 64'(w), 64'd0);
      check($sformatf("tp%0d_out_valid", i), 64'(ov), 64'd1);
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("tp_drained", 64'(sb.size()), 64'd0);

    // Asynchronous reset with a full buffer.
    out_ready = 1'b0;
    send(18'h00AAA, 2'b01, 4'hC, 32'h00000AAA, 1'b0, w, ov);
    send(18'h00BBB, 2'b01, 4'hD, 32'h00000BBB, 1'b0, w, ov);
    in_valid = 1'b0;
    @(negedge clk);
    check("full_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_out_imm", 64'(out_imm), 64'd0);
    check("arst_out_tag", 64'(out_tag), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    @(posedge clk); #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_out_valid", 64'(out_valid), 64'd0);
      check("post_rst_in_ready", 64'(in_ready), 64'd1);
    end
    @(posedge clk); #1;
    send(18'h00777, 2'b00, 4'hE, 32'h00000777, 1'b0, w, ov);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_drained", 64'(sb.size()), 64'd0);

    // 16->16 instance: scaled-mode overflow and pass-through modes.
    for (int i = 0; i < 6; i++) begin
      d2_in_valid = 1'b1;
      d2_in_imm   = v16[i].imm[15:0];
      d2_in_mode  = v16[i].mode;
      d2_in_tag   = v16[i].tag;
      @(negedge clk);
      check($sformatf("w16_%0d_in_ready", i), 64'(d2_in_ready), 64'd1);
      @(posedge clk); #1;
      d2_in_valid = 1'b0;
      @(negedge clk);
      check($sformatf("w16_%0d_valid", i), 64'(d2_out_valid), 64'd1);
      check($sformatf("w16_%0d_imm", i), 64'(d2_out_imm), 64'(v16[i].exp_imm[15:0]));
      check($sformatf("w16_%0d_ovf", i), 64'(d2_out_ovf), 64'(v16[i].exp_ovf));
      check($sformatf("w16_%0d_tag", i), 64'(d2_out_tag), 64'(v16[i].tag));
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
